// File: rtl/ic_gate_sequencer.sv
// ---------------------------------------------------------------------------
// ic_gate_sequencer
//   Test sequencer for quad/hex 2-input 74-series logic ICs. Latches the IC
//   number on an accepted start and decodes it to a gate function. Walks the
//   four {A,B} vectors across all gates in parallel. Each vector is held for
//   SETTLE_CYCLES before gate_y is sampled against the expected output.
//   Reports sticky per-gate and overall pass/fail.
//
// Ports
//   clk          system clock
//   Rkey         asynchronous active-low reset
//   start        one-cycle start request, honoured only in IDLE
//   ic_number    decimal IC number, latched on accepted start
//   gate_a/b     logical A/B inputs driven to every gate under test
//   gate_y       logical Y outputs read back from every gate
//   busy         high in LOAD/SETTLE/SAMPLE
//   done         one-cycle pulse when results are valid
//   unsupported  latched number is not a known part
//   pass_vec     per-gate pass (valid from done, held until next start)
//   fail_vec     per-gate sticky fail
//   pass / fail  all gates passed / any gate failed
// ---------------------------------------------------------------------------

// Per-gate checker: sticky fail bit plus its next value. The next value lets
// the final verdict include the last sample in the same cycle.
module ic_gate_lane (
    input  logic clk,
    input  logic Rkey,
    input  logic clr,
    input  logic sample,
    input  logic exp_y,
    input  logic y,
    output logic fail_q,
    output logic fail_nx
);
    assign fail_nx = fail_q | (sample & (y ^ exp_y));

    always_ff @(posedge clk or negedge Rkey) begin
        if (!Rkey)    fail_q <= 1'b0;
        else if (clr) fail_q <= 1'b0;
        else          fail_q <= fail_nx;
    end
endmodule

module ic_gate_sequencer #(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 50,
    parameter int ICNUM_W       = 32
) (
    input  logic                 clk,
    input  logic                 Rkey,
    input  logic                 start,
    input  logic [ICNUM_W-1:0]   ic_number,
    output logic [NUM_GATES-1:0] gate_a,
    output logic [NUM_GATES-1:0] gate_b,
    input  logic [NUM_GATES-1:0] gate_y,
    output logic                 busy,
    output logic                 done,
    output logic                 unsupported,
    output logic [NUM_GATES-1:0] pass_vec,
    output logic [NUM_GATES-1:0] fail_vec,
    output logic                 pass,
    output logic                 fail
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_DONE} state_t;
    typedef enum logic [2:0] {F_NAND, F_NOR, F_AND, F_OR, F_XOR, F_XNOR, F_NONE} func_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t               state;
    func_t                func;
    logic [ICNUM_W-1:0]   ic_q;
    logic [1:0]           v;
    logic [1:0]           v_nx;
    logic [CNT_W-1:0]     cnt;
    logic                 exp_y;
    logic                 clr;
    logic                 sample;
    logic [NUM_GATES-1:0] fail_nx;

    // Function decode works on the latched number. Later changes on the input
    // cannot disturb a run in progress.
    always_comb begin
        func = F_NONE;
        case (ic_q)
            ICNUM_W'(7400):   func = F_NAND;
            ICNUM_W'(7402):   func = F_NOR;
            ICNUM_W'(7408):   func = F_AND;
            ICNUM_W'(7432):   func = F_OR;
            ICNUM_W'(7486):   func = F_XOR;
            ICNUM_W'(747266): func = F_XNOR;
            default:          func = F_NONE;
        endcase
    end

    // Expected Y for the current vector; {A,B} = v
    always_comb begin
        exp_y = 1'b0;
        case (func)
            F_NAND:  exp_y = ~(v[1] & v[0]);
            F_NOR:   exp_y = ~(v[1] | v[0]);
            F_AND:   exp_y = v[1] & v[0];
            F_OR:    exp_y = v[1] | v[0];
            F_XOR:   exp_y = v[1] ^ v[0];
            F_XNOR:  exp_y = ~(v[1] ^ v[0]);
            default: exp_y = 1'b0;
        endcase
    end

    assign v_nx   = v + 2'd1;
    assign clr    = (state == S_IDLE) && start;
    assign sample = (state == S_SAMPLE);

    ic_gate_lane u_lane [NUM_GATES-1:0] (
        .clk     (clk),
        .Rkey    (Rkey),
        .clr     (clr),
        .sample  (sample),
        .exp_y   (exp_y),
        .y       (gate_y),
        .fail_q  (fail_vec),
        .fail_nx (fail_nx)
    );

    always_ff @(posedge clk or negedge Rkey) begin
        if (!Rkey) begin
            state       <= S_IDLE;
            ic_q        <= '0;
            v           <= '0;
            cnt         <= '0;
            gate_a      <= '0;
            gate_b      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            unsupported <= 1'b0;
            pass_vec    <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        ic_q        <= ic_number;
                        busy        <= 1'b1;
                        unsupported <= 1'b0;
                        pass_vec    <= '0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                    end
                end
                S_LOAD: begin
                    v   <= '0;
                    cnt <= '0;
                    if (func == F_NONE) begin
                        state       <= S_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        unsupported <= 1'b1;
                    end else begin
                        state  <= S_SETTLE;
                        gate_a <= '0;
                        gate_b <= '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (v == 2'd3) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass_vec <= ~fail_nx;
                        pass     <= ~|fail_nx;
                        fail     <= |fail_nx;
                    end else begin
                        v      <= v_nx;
                        gate_a <= {NUM_GATES{v_nx[1]}};
                        gate_b <= {NUM_GATES{v_nx[0]}};
                        state  <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    gate_a <= '0;
                    gate_b <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ic_gate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ic_gate_sequencer
//   Directed bench. The driver pushes the expected result of each run into a
//   scoreboard queue. A negedge monitor pops and compares it whenever done
//   pulses. The monitor also checks the vector presented at every SAMPLE
//   cycle, and checks that the gates rest at 0 when idle.
// ---------------------------------------------------------------------------
module tb_ic_gate_sequencer;
    localparam int N = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         Rkey = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  ic_number = '0;
    logic [N-1:0] gate_a, gate_b, gate_y, pass_vec, fail_vec;
    logic         busy, done, unsupported, pass, fail;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gmode [N];

    typedef struct {
        int           done_cyc;
        logic [N-1:0] pv;
        logic [N-1:0] fv;
        logic         p;
        logic         f;
        logic         u;
    } exp_t;
    exp_t sb[$];

    ic_gate_sequencer #(.NUM_GATES(N), .SETTLE_CYCLES(S), .ICNUM_W(32)) dut (
        .clk(clk), .Rkey(Rkey), .start(start), .ic_number(ic_number),
        .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
        .busy(busy), .done(done), .unsupported(unsupported),
        .pass_vec(pass_vec), .fail_vec(fail_vec), .pass(pass), .fail(fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate model modes: 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 stuck-1, 7 stuck-0
    function automatic logic gmodel(int m, logic a, logic b);
        case (m)
            0:       return ~(a & b);
            1:       return ~(a | b);
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return ~(a ^ b);
            6:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        gate_y = '0;
        for (int i = 0; i < N; i++) gate_y[i] = gmodel(gmode[i], gate_a[i], gate_b[i]);
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- monitor ----------------
    initial begin
        int   load_cyc;
        int   k;
        logic busy_d;
        logic [1:0] kb;
        exp_t e;
        load_cyc = -100;
        busy_d   = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !busy_d) load_cyc = cyc;
            busy_d = busy;
            if (busy && cyc >= load_cyc + S + 1 && ((cyc - load_cyc - S - 1) % (S + 1)) == 0) begin
                k = (cyc - load_cyc - S - 1) / (S + 1);
                if (k < 4) begin
                    kb = 2'(k);
                    chk("sample_gate_a", 64'(gate_a), 64'({N{kb[1]}}));
                    chk("sample_gate_b", 64'(gate_b), 64'({N{kb[0]}}));
                end
            end
            if (Rkey && !busy && !done)
                chk("idle_gates_zero", 64'({gate_a, gate_b}), 64'(0));
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle",  64'(cyc),         64'(e.done_cyc));
                    chk("pass_vec",    64'(pass_vec),    64'(e.pv));
                    chk("fail_vec",    64'(fail_vec),    64'(e.fv));
                    chk("pass",        64'(pass),        64'(e.p));
                    chk("fail",        64'(fail),        64'(e.f));
                    chk("unsupported", 64'(unsupported), 64'(e.u));
                    chk("busy_in_done", 64'(busy),       64'(0));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_all(int m);
        for (int i = 0; i < N; i++) gmode[i] = m;
    endtask

    task automatic issue(int num, logic [N-1:0] pv, logic [N-1:0] fv,
                         logic p, logic f, logic u, output int c);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        ic_number = 32'(num);
        c          = cyc;
        e.done_cyc = c + (u ? 2 : 2 + 4 * (S + 1));
        e.pv = pv; e.fv = fv; e.p = p; e.f = f; e.u = u;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sb(int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 64'(sb.size()), 64'(0));
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c;
        #200000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        set_all(2);
        #1 Rkey = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy, done, unsupported, pass, fail, pass_vec, fail_vec, gate_a, gate_b}), 64'(0));
        Rkey = 1'b1;
        repeat (2) @(negedge clk);

        // 1: good AND gates
        set_all(2);
        issue(7408, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, c);
        wait_sb(40);
        repeat (5) @(negedge clk);
        chk("hold_pass_vec", 64'(pass_vec), 64'(4'b1111));
        chk("hold_pass",     64'(pass),     64'(1));

        // 2: NAND, gate 2 stuck at 1
        set_all(0);
        gmode[2] = 6;
        issue(7400, 4'b1011, 4'b0100, 1'b0, 1'b1, 1'b0, c);
        wait_sb(40);
        chk("hold_fail_vec", 64'(fail_vec), 64'(4'b0100));

        // 3: XOR, gate 0 behaves as OR
        set_all(4);
        gmode[0] = 3;
        issue(7486, 4'b1110, 4'b0001, 1'b0, 1'b1, 1'b0, c);
        wait_sb(40);

        // 4: unsupported part
        issue(7474, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, c);
        wait_sb(40);
        chk("hold_unsupported", 64'(unsupported), 64'(1));

        // 5: OR run with stray starts (including one during DONE) and a
        //    mid-run ic_number change to 7408
        set_all(3);
        issue(7432, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, c);
        while (cyc < c + 15) begin
            @(negedge clk);
            ic_number = (cyc >= c + 3) ? 32'd7408 : 32'd7432;
            start     = (cyc == c + 5 || cyc == c + 9 || cyc == c + 14);
        end
        start = 1'b0;
        wait_sb(40);
        repeat (20) @(negedge clk);
        chk("no_rerun_busy", 64'(busy), 64'(0));

        // 6: reset during SETTLE of v=2, then a clean NOR run
        @(negedge clk);
        start     = 1'b1;
        ic_number = 32'd7432;
        c         = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 9) @(negedge clk);
        chk("pre_reset_gate_a", 64'(gate_a), 64'(4'b1111));
        Rkey = 1'b0;
        #1;
        chk("async_rst_busy",    64'(busy), 64'(0));
        chk("async_rst_gates",   64'({gate_a, gate_b}), 64'(0));
        chk("async_rst_results", 64'({done, unsupported, pass, fail, pass_vec, fail_vec}), 64'(0));
        repeat (2) @(negedge clk);
        Rkey = 1'b1;
        set_all(1);
        issue(7402, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, c);
        wait_sb(40);

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
